// File: rtl/braid_seq_pkg.sv
// Shared types and constants for the braided mixer sequencer.
package braid_seq_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FILL,
      S_MIX,
      S_FLUSH,
      S_DONE
   } seq_state_t;

   localparam int STAGES_DEF       = 16;
   localparam int STAGE_CNT_W_DEF  = $clog2(STAGES_DEF + 1);
   localparam int STAGE_IDX_W_DEF  = $clog2(STAGES_DEF);
   localparam int FILL_CYCLES_DEF  = 32;
   localparam int FLUSH_CYCLES_DEF = 32;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/braid_seq_onehot.sv
// Stage index to one-hot pump decoder; all zeros when not enabled.
module braid_seq_onehot
   import braid_seq_pkg::*;
#(
   parameter int N  = STAGES_DEF,
   parameter int IW = STAGE_IDX_W_DEF
) (
   input  logic [IW-1:0] idx,
   input  logic          en,
   output logic [N-1:0]  onehot
);

   // single bit set at idx while enabled
   always_comb begin
      onehot = '0;
      if (en) onehot[idx] = 1'b1;
   end

endmodule

// File: rtl/braid_mix_sequencer.sv
// Fill / mix / flush timing sequencer for the braided mixer network.
// Optional abort input and aborted flag are built when BRAID_SEQ_ABORT_EN is defined.
//
// state   | meaning
// --------+-----------------------------------------------
// S_IDLE  | waiting for a request, req_ready=1
// S_FILL  | inlet valves open for FILL_CYCLES
// S_MIX   | one stage pump at a time, dwell cycles each
// S_FLUSH | outlet valves open for FLUSH_CYCLES
// S_DONE  | one-cycle done pulse, then back to idle
module braid_mix_sequencer
   import braid_seq_pkg::*;
#(
   parameter int LANES        = 4,
   parameter int STAGES       = STAGES_DEF,
   parameter int DWELL_W      = 8,
   parameter int FILL_CYCLES  = FILL_CYCLES_DEF,
   parameter int FLUSH_CYCLES = FLUSH_CYCLES_DEF
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         req_valid,
   output logic                         req_ready,
   input  logic [LANES-1:0]             req_lane_mask,
   input  logic [$clog2(STAGES+1)-1:0]  req_stages,
   input  logic [DWELL_W-1:0]           req_dwell,
   output logic [LANES-1:0]             inlet_valve,
   output logic [STAGES-1:0]            stage_pump,
   output logic [LANES-1:0]             outlet_valve,
   output logic [$clog2(STAGES)-1:0]    stage_idx,
   output logic                         busy,
   output logic                         done
`ifdef BRAID_SEQ_ABORT_EN
   ,
   input  logic                         abort,
   output logic                         aborted
`endif
);

   localparam int CNT_W = $clog2(STAGES + 1);
   localparam int IDX_W = $clog2(STAGES);
   localparam int PH_W  = $clog2(max_int(FILL_CYCLES, FLUSH_CYCLES) + 1);

   seq_state_t          state_q, state_nxt;
   logic [LANES-1:0]    mask_q, mask_nxt;
   logic [CNT_W-1:0]    stages_q, stages_nxt;
   logic [DWELL_W-1:0]  dwell_q, dwell_nxt;
   logic [DWELL_W-1:0]  dcnt_q, dcnt_nxt;
   logic [PH_W-1:0]     phase_q, phase_nxt;
   logic [IDX_W-1:0]    stage_q, stage_nxt;
   logic [STAGES-1:0]   pump_dec;
   logic                accept;
   logic                abort_hit;
   logic                last_stage;

   assign accept     = req_valid && req_ready;
   assign last_stage = (CNT_W'(stage_q) + CNT_W'(1)) == stages_q;

`ifdef BRAID_SEQ_ABORT_EN
   assign abort_hit = abort;
`else
   assign abort_hit = 1'b0;
`endif

   // next state, counters and latched request fields
   always_comb begin
      state_nxt  = state_q;
      mask_nxt   = mask_q;
      stages_nxt = stages_q;
      dwell_nxt  = dwell_q;
      dcnt_nxt   = dcnt_q;
      phase_nxt  = phase_q;
      stage_nxt  = stage_q;
      unique case (state_q)
         S_IDLE: begin
            if (accept) begin
               mask_nxt   = req_lane_mask;
               stages_nxt = (req_stages > CNT_W'(STAGES)) ? CNT_W'(STAGES) : req_stages;
               dwell_nxt  = (req_dwell == '0) ? DWELL_W'(1) : req_dwell;
               stage_nxt  = '0;
               if (req_lane_mask == '0) begin
                  state_nxt = S_DONE;
               end else begin
                  state_nxt = S_FILL;
                  phase_nxt = PH_W'(FILL_CYCLES);
               end
            end
         end
         S_FILL: begin
            if (abort_hit || (phase_q == PH_W'(1) && stages_q == '0)) begin
               state_nxt = S_FLUSH;
               phase_nxt = PH_W'(FLUSH_CYCLES);
            end else if (phase_q == PH_W'(1)) begin
               state_nxt = S_MIX;
               stage_nxt = '0;
               dcnt_nxt  = dwell_q;
            end else begin
               phase_nxt = phase_q - PH_W'(1);
            end
         end
         S_MIX: begin
            if (abort_hit || (dcnt_q == DWELL_W'(1) && last_stage)) begin
               state_nxt = S_FLUSH;
               phase_nxt = PH_W'(FLUSH_CYCLES);
               stage_nxt = '0;
            end else if (dcnt_q == DWELL_W'(1)) begin
               stage_nxt = stage_q + IDX_W'(1);
               dcnt_nxt  = dwell_q;
            end else begin
               dcnt_nxt = dcnt_q - DWELL_W'(1);
            end
         end
         S_FLUSH: begin
            if (phase_q == PH_W'(1)) state_nxt = S_DONE;
            else                     phase_nxt = phase_q - PH_W'(1);
         end
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   braid_seq_onehot #(.N(STAGES), .IW(IDX_W)) u_onehot (
      .idx    (stage_nxt),
      .en     (state_nxt == S_MIX),
      .onehot (pump_dec)
   );

   // state register and working counters
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         mask_q   <= '0;
         stages_q <= '0;
         dwell_q  <= '0;
         dcnt_q   <= '0;
         phase_q  <= '0;
         stage_q  <= '0;
      end else begin
         state_q  <= state_nxt;
         mask_q   <= mask_nxt;
         stages_q <= stages_nxt;
         dwell_q  <= dwell_nxt;
         dcnt_q   <= dcnt_nxt;
         phase_q  <= phase_nxt;
         stage_q  <= stage_nxt;
      end
   end

   // actuator and handshake outputs registered from the upcoming state
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         req_ready    <= 1'b1;
         busy         <= 1'b0;
         done         <= 1'b0;
         inlet_valve  <= '0;
         stage_pump   <= '0;
         outlet_valve <= '0;
         stage_idx    <= '0;
      end else begin
         req_ready    <= (state_nxt == S_IDLE);
         busy         <= (state_nxt == S_FILL) || (state_nxt == S_MIX) || (state_nxt == S_FLUSH);
         done         <= (state_nxt == S_DONE);
         inlet_valve  <= (state_nxt == S_FILL)  ? mask_nxt : '0;
         outlet_valve <= (state_nxt == S_FLUSH) ? mask_nxt : '0;
         stage_pump   <= pump_dec;
         stage_idx    <= (state_nxt == S_MIX) ? stage_nxt : '0;
      end
   end

`ifdef BRAID_SEQ_ABORT_EN
   logic abort_pend;

   // remember an abort during the run and expose it alongside done
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         abort_pend <= 1'b0;
         aborted    <= 1'b0;
      end else if (accept) begin
         abort_pend <= 1'b0;
         aborted    <= 1'b0;
      end else begin
         if (abort_hit && (state_q == S_FILL || state_q == S_MIX)) abort_pend <= 1'b1;
         if (state_nxt == S_DONE && abort_pend) aborted <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_braid_mix_sequencer.sv
// Scoreboard bench for braid_mix_sequencer: expected per-cycle outputs are
// queued at acceptance and compared each cycle on the falling edge.
module tb_braid_mix_sequencer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [3:0]  req_lane_mask = 4'b0;
   logic [4:0]  req_stages = 5'b0;
   logic [7:0]  req_dwell = 8'b0;
   logic [3:0]  inlet_valve;
   logic [15:0] stage_pump;
   logic [3:0]  outlet_valve;
   logic [3:0]  stage_idx;
   logic        busy;
   logic        done;
`ifdef BRAID_SEQ_ABORT_EN
   logic        abort = 1'b0;
   logic        aborted;
`endif

   int          n_checks = 0;
   int          n_fail   = 0;
   int          cyc      = 0;
   int          acc_cyc  = 0;
   int          exp_lat  = 0;
   bit          lat_arm  = 1'b0;
   logic [63:0] exp_q[$];

   braid_mix_sequencer dut (
      .clk           (clk),
      .rst           (rst),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_lane_mask (req_lane_mask),
      .req_stages    (req_stages),
      .req_dwell     (req_dwell),
      .inlet_valve   (inlet_valve),
      .stage_pump    (stage_pump),
      .outlet_valve  (outlet_valve),
      .stage_idx     (stage_idx),
      .busy          (busy),
`ifdef BRAID_SEQ_ABORT_EN
      .done          (done),
      .abort         (abort),
      .aborted       (aborted)
`else
      .done          (done)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s observed=%0h expected=%0h at cycle %0d", tag, obs, exp, cyc);
      end
   endtask

   function automatic logic [63:0] pk(input logic [3:0] inl, input logic [15:0] pump,
                                      input logic [3:0] outl, input logic [3:0] idx,
                                      input logic b, input logic d, input logic r);
      return {33'b0, inl, pump, outl, idx, b, d, r};
   endfunction

   function automatic logic [63:0] obs_vec();
      return pk(inlet_valve, stage_pump, outlet_valve, stage_idx, busy, done, req_ready);
   endfunction

   // reference model: expected outputs for every cycle after acceptance
   function automatic void push_run(input logic [3:0] m, input int st, input int dw, input int ab);
      int s = (st > 16) ? 16 : st;
      int d = (dw == 0) ? 1 : dw;
      int n = 0;
      int mi = 0;
      bit stop = 1'b0;
      if (m == 4'b0) begin
         exp_q.push_back(pk(4'b0, 16'b0, 4'b0, 4'b0, 1'b0, 1'b1, 1'b0));
         exp_q.push_back(pk(4'b0, 16'b0, 4'b0, 4'b0, 1'b0, 1'b0, 1'b1));
         exp_lat = 1;
         return;
      end
      for (int i = 0; i < 32; i++) begin
         exp_q.push_back(pk(m, 16'b0, 4'b0, 4'b0, 1'b1, 1'b0, 1'b0));
         n++;
      end
      for (int k = 0; k < s && !stop; k++) begin
         for (int j = 0; j < d && !stop; j++) begin
            exp_q.push_back(pk(4'b0, 16'(1) << k, 4'b0, 4'(k), 1'b1, 1'b0, 1'b0));
            if (mi == ab) stop = 1'b1;
            mi++;
            n++;
         end
      end
      for (int i = 0; i < 32; i++) begin
         exp_q.push_back(pk(4'b0, 16'b0, m, 4'b0, 1'b1, 1'b0, 1'b0));
         n++;
      end
      exp_q.push_back(pk(4'b0, 16'b0, 4'b0, 4'b0, 1'b0, 1'b1, 1'b0));
      exp_q.push_back(pk(4'b0, 16'b0, 4'b0, 4'b0, 1'b0, 1'b0, 1'b1));
      exp_lat = n + 1;
   endfunction

   // per-cycle monitor: exclusion invariant, scoreboard pop, done latency
   always @(negedge clk) begin
      logic [63:0] e;
      logic        excl;
      cyc++;
      excl = !(((|inlet_valve) && (|stage_pump)) || ((|inlet_valve) && (|outlet_valve)) ||
               ((|stage_pump) && (|outlet_valve)));
      chk("mutex", 64'(excl), 64'(1));
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("cycle", obs_vec(), e);
      end
      if (done && lat_arm) begin
         chk("latency", 64'(cyc - acc_cyc), 64'(exp_lat));
         lat_arm = 1'b0;
      end
   end

   task automatic run_req(input logic [3:0] m, input int st, input int dw, input int ab, input bit sb);
      int w = 0;
      while (req_ready !== 1'b1 && w < 200) begin
         @(negedge clk);
         #1;
         w++;
      end
      chk("ready_wait", 64'(req_ready), 64'(1));
      req_valid     = 1'b1;
      req_lane_mask = m;
      req_stages    = 5'(st);
      req_dwell     = 8'(dw);
      @(posedge clk);
      if (sb) begin
         acc_cyc = cyc;
         push_run(m, st, dw, ab);
         lat_arm = 1'b1;
      end
      #1;
      req_valid = 1'b0;
   endtask

   task automatic wait_drain();
      int w = 0;
      while (exp_q.size() != 0 && w < 300) begin
         @(negedge clk);
         #1;
         w++;
      end
      chk("drain", 64'(exp_q.size()), 64'(0));
   endtask

   initial begin
      int w;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("reset", obs_vec(), pk(4'b0, 16'b0, 4'b0, 4'b0, 1'b0, 1'b0, 1'b1));

      run_req(4'b0101, 3, 2, -1, 1'b1);
      wait_drain();
      run_req(4'b1111, 0, 5, -1, 1'b1);
      wait_drain();
      run_req(4'b1010, 20, 0, -1, 1'b1);
      wait_drain();
      run_req(4'b0000, 7, 3, -1, 1'b1);
      wait_drain();
      run_req(4'b0110, 1, 1, -1, 1'b1);
      wait_drain();

      // reset while mixing stage 5
      run_req(4'b0011, 8, 2, -1, 1'b0);
      w = 0;
      while (stage_idx != 4'd5 && w < 100) begin
         @(negedge clk);
         w++;
      end
      chk("reach_stage5", 64'(stage_idx), 64'(5));
      #2;
      rst = 1'b1;
      #1;
      chk("rst_async", 64'({inlet_valve, stage_pump, outlet_valve, stage_idx, busy, done}), 64'(0));
      repeat (3) begin
         @(negedge clk);
         chk("rst_nodone", 64'(done), 64'(0));
      end
      rst = 1'b0;
      #1;
      chk("rst_release", obs_vec(), pk(4'b0, 16'b0, 4'b0, 4'b0, 1'b0, 1'b0, 1'b1));
      run_req(4'b1001, 2, 3, -1, 1'b1);
      wait_drain();

`ifdef BRAID_SEQ_ABORT_EN
      chk("aborted_clear", 64'(aborted), 64'(0));
      // abort on the first cycle of stage 2 (mix cycle index 6)
      run_req(4'b0101, 4, 3, 6, 1'b1);
      repeat (39) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      wait_drain();
      chk("aborted_set", 64'(aborted), 64'(1));
`endif

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
